vga_frame_ctrl: RTL and testbench

- Sequences start-up and operation of vga_sync_gen in a pixel-clock domain.
- Holds the sync generator in reset until the pixel PLL has been stably locked, then releases it.
- Enables video only from the first clean frame boundary onward.
- Produces per-frame events and the nyancat animation frame index used by the pixel pipeline.

---
 rtl/vga_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vga_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_ctrl.sv
// Start-up sequencer and frame/animation timing for vga_sync_gen: waits for a
// stable pixel-PLL lock, releases the sync generator, then enables video at the first clean frame.
module vga_frame_ctrl #(
  parameter int LOCK_CYCLES     = 1024,
  parameter int FRAMES_PER_STEP = 6,
  parameter int ANIM_FRAMES     = 12,
  parameter int FRAME_W         = 4
) (
  input  logic               px_clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               vsync,
  input  logic               anim_pause,
  output logic               sync_reset,
  output logic               video_en,
  output logic               frame_start,
  output logic               anim_tick,
  output logic [FRAME_W-1:0] anim_frame,
  output logic [15:0]        frame_count
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES);
  localparam int DIV_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [FRAME_W-1:0] ANIM_LAST = FRAME_W'(ANIM_FRAMES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    SYNC_WAIT = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_locked_s;
  logic                r_vsync_q;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [DIV_W-1:0]    r_div;
  logic                r_sync_reset;
  logic                r_video_en;
  logic                r_frame_start;
  logic                r_anim_tick;
  logic [FRAME_W-1:0]  r_anim_frame;
  logic [15:0]         r_frame_count;

  logic                w_rise;
  logic                w_div_wrap;
  logic [FRAME_W-1:0]  w_anim_next;

  // Rising vsync (active low) marks the end of the sync pulse.
  assign w_rise      = !r_vsync_q && vsync;
  assign w_div_wrap  = (r_div == DIV_LAST);
  assign w_anim_next = (r_anim_frame == ANIM_LAST) ? '0 : r_anim_frame + 1'b1;

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= WAIT_LOCK;
      r_sync1       <= 1'b0;
      r_locked_s    <= 1'b0;
      r_vsync_q     <= 1'b1;
      r_lock_cnt    <= '0;
      r_div         <= '0;
      r_sync_reset  <= 1'b1;
      r_video_en    <= 1'b0;
      r_frame_start <= 1'b0;
      r_anim_tick   <= 1'b0;
      r_anim_frame  <= '0;
      r_frame_count <= '0;
    end else begin
      r_sync1       <= pll_locked;
      r_locked_s    <= r_sync1;
      r_vsync_q     <= vsync;
      r_frame_start <= 1'b0;
      r_anim_tick   <= 1'b0;

      case (r_state)
        WAIT_LOCK: begin
          r_sync_reset <= 1'b1;
          r_video_en   <= 1'b0;
          if (!r_locked_s) begin
            r_lock_cnt <= '0;
          end else if (r_lock_cnt == LOCK_LAST) begin
            r_lock_cnt <= '0;
            r_state    <= RELEASE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (!r_locked_s) begin
            r_state      <= WAIT_LOCK;
            r_sync_reset <= 1'b1;
            r_video_en   <= 1'b0;
            r_div        <= '0;
            r_lock_cnt   <= '0;
          end else begin
            r_sync_reset <= 1'b0;
            r_state      <= SYNC_WAIT;
          end
        end

        SYNC_WAIT, RUN: begin
          // Lock loss wins over a coincident rise; frame/anim position is kept.
          if (!r_locked_s) begin
            r_state      <= WAIT_LOCK;
            r_sync_reset <= 1'b1;
            r_video_en   <= 1'b0;
            r_div        <= '0;
            r_lock_cnt   <= '0;
          end else if (w_rise) begin
            r_state       <= RUN;
            r_video_en    <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            if (!anim_pause) begin
              if (w_div_wrap) begin
                r_div        <= '0;
                r_anim_tick  <= 1'b1;
                r_anim_frame <= w_anim_next;
              end else begin
                r_div <= r_div + 1'b1;
              end
            end
          end
        end

        default: begin
          r_state      <= WAIT_LOCK;
          r_sync_reset <= 1'b1;
          r_video_en   <= 1'b0;
          r_div        <= '0;
          r_lock_cnt   <= '0;
        end
      endcase
    end
  end

  assign sync_reset  = r_sync_reset;
  assign video_en    = r_video_en;
  assign frame_start = r_frame_start;
  assign anim_tick   = r_anim_tick;
  assign anim_frame  = r_anim_frame;
  assign frame_count = r_frame_count;

`ifndef SYNTHESIS
  always @(posedge px_clk) begin
    assert (LOCK_CYCLES >= 2 && FRAMES_PER_STEP >= 1 && ANIM_FRAMES >= 2 &&
            ANIM_FRAMES <= (1 << FRAME_W))
      else $error("vga_frame_ctrl: illegal parameter set");
    if (reset_n) begin
      assert (int'(r_anim_frame) < ANIM_FRAMES)
        else $error("vga_frame_ctrl: anim_frame out of range");
      assert (!r_anim_tick || r_frame_start)
        else $error("vga_frame_ctrl: anim_tick without frame_start");
      assert (!r_video_en || !r_sync_reset)
        else $error("vga_frame_ctrl: video enabled while sync held in reset");
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Randomized scenario bench for vga_frame_ctrl with a frame-level reference model
// (frame count, step divider and animation index tracked arithmetically).
module tb_vga_frame_ctrl;

  localparam int LOCK  = 4;
  localparam int FPS   = 2;
  localparam int NANIM = 3;

  logic        px_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pll_locked = 1'b1;
  logic        vsync = 1'b1;
  logic        anim_pause = 1'b0;
  logic        sync_reset;
  logic        video_en;
  logic        frame_start;
  logic        anim_tick;
  logic [3:0]  anim_frame;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  int m_fc;
  int m_div;
  int m_anim;

  vga_frame_ctrl #(
    .LOCK_CYCLES    (LOCK),
    .FRAMES_PER_STEP(FPS),
    .ANIM_FRAMES    (NANIM),
    .FRAME_W        (4)
  ) dut (
    .px_clk     (px_clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .vsync      (vsync),
    .anim_pause (anim_pause),
    .sync_reset (sync_reset),
    .video_en   (video_en),
    .frame_start(frame_start),
    .anim_tick  (anim_tick),
    .anim_frame (anim_frame),
    .frame_count(frame_count)
  );

  always #5 px_clk = ~px_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge px_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pll_locked = 1'b1;
    vsync = 1'b1;
    anim_pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({sync_reset, video_en, frame_start, anim_tick, anim_frame, frame_count} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0}) begin
        errors++;
        $display("FAIL reset_values: got sr=%0b ve=%0b fs=%0b at=%0b af=%0d fc=%0d, expected 1 0 0 0 0 0",
                 sync_reset, video_en, frame_start, anim_tick, anim_frame, frame_count);
      end
    end
    reset_n = 1'b1;
    m_fc = 0;
    m_div = 0;
    m_anim = 0;
    $display("reset released");
  endtask

  // pat bit k-1 is the pll_locked level presented for clock edge k.
  task automatic bring_up(input logic [31:0] pat, input bit vsync_dip);
    int   run;
    int   exp_fall;
    logic exp_sr;
    run = 0;
    exp_fall = 0;
    for (int k = 1; k <= 40; k++) begin
      pll_locked = (k <= 32) ? pat[k-1] : 1'b1;
      if (vsync_dip) vsync = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      cyc();
      run = pll_locked ? run + 1 : 0;
      if (run == LOCK && exp_fall == 0) exp_fall = k + 3;
      exp_sr = !(exp_fall != 0 && k >= exp_fall);
      checks++;
      if (sync_reset !== exp_sr) begin
        errors++;
        $display("FAIL sync_reset_release: edge %0d got %0b, expected %0b", k, sync_reset, exp_sr);
      end
      checks++;
      if ({video_en, frame_start, anim_tick} !== 3'b000) begin
        errors++;
        $display("FAIL startup_quiet: edge %0d got ve/fs/at=%b, expected 000", k,
                 {video_en, frame_start, anim_tick});
      end
      if (exp_fall != 0 && k == exp_fall) begin
        $display("sync_reset released at edge %0d", k);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL bring_up_timeout: sync_reset release expected by edge %0d, got none", exp_fall);
  endtask

  task automatic do_frame(input bit pause, input int tail);
    int lo;
    bit exp_tick;
    anim_pause = pause;
    vsync = 1'b0;
    lo = $urandom_range(2, 5);
    for (int i = 0; i < lo; i++) begin
      cyc();
      checks++;
      if ({frame_start, anim_tick} !== 2'b00) begin
        errors++;
        $display("FAIL sync_pulse_quiet: got fs/at=%b, expected 00", {frame_start, anim_tick});
      end
    end
    vsync = 1'b1;
    cyc();
    m_fc = (m_fc + 1) & 16'hFFFF;
    exp_tick = 1'b0;
    if (!pause) begin
      m_div++;
      if (m_div == FPS) begin
        m_div = 0;
        exp_tick = 1'b1;
        m_anim = (m_anim + 1) % NANIM;
      end
    end
    checks++;
    if (video_en !== 1'b1) begin
      errors++;
      $display("FAIL frame_video_en: got %0b, expected 1", video_en);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start: got %0b, expected 1", frame_start);
    end
    checks++;
    if (anim_tick !== exp_tick) begin
      errors++;
      $display("FAIL anim_tick: got %0b, expected %0b", anim_tick, exp_tick);
    end
    checks++;
    if (anim_frame !== 4'(m_anim)) begin
      errors++;
      $display("FAIL anim_frame: got %0d, expected %0d", anim_frame, m_anim);
    end
    checks++;
    if (frame_count !== 16'(m_fc)) begin
      errors++;
      $display("FAIL frame_count: got %0d, expected %0d", frame_count, m_fc);
    end
    $display("frame fc=%0d anim=%0d tick=%0b pause=%0b", frame_count, anim_frame, anim_tick, pause);
    for (int i = 0; i < tail; i++) begin
      cyc();
      checks++;
      if ({frame_start, anim_tick} !== 2'b00) begin
        errors++;
        $display("FAIL pulse_width: got fs/at=%b, expected 00", {frame_start, anim_tick});
      end
    end
  endtask

  task automatic test_startup();
    test_reset();
    bring_up(32'hFFFF_FFFF, 1'b1);
    do_frame(1'b0, 4);
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL first_frame_count: got %0d, expected 1", frame_count);
    end
  endtask

  task automatic test_lock_glitch();
    test_reset();
    bring_up(32'hFFFF_FFF7, 1'b0);
    do_frame(1'b0, 3);
  endtask

  task automatic test_animation();
    test_reset();
    bring_up(32'hFFFF_FFFF, 1'b0);
    for (int f = 1; f <= 8; f++) do_frame(1'b0, $urandom_range(3, 6));
    checks++;
    if ({anim_frame, frame_count} !== {4'd1, 16'd8}) begin
      errors++;
      $display("FAIL animation_end: got af=%0d fc=%0d, expected af=1 fc=8", anim_frame, frame_count);
    end
  endtask

  task automatic test_pause();
    test_reset();
    bring_up(32'hFFFF_FFFF, 1'b0);
    for (int f = 1; f <= 8; f++) begin
      do_frame(f >= 3 && f <= 5, $urandom_range(3, 6));
      if (f == 5) begin
        checks++;
        if ({anim_frame, frame_count} !== {4'd1, 16'd5}) begin
          errors++;
          $display("FAIL pause_hold: got af=%0d fc=%0d, expected af=1 fc=5", anim_frame, frame_count);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int prev_fc;
    anim_pause = 1'b0;
    vsync = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    pll_locked = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({sync_reset, video_en} !== 2'b01) begin
        errors++;
        $display("FAIL loss_sync_latency: got sr/ve=%b, expected 01", {sync_reset, video_en});
      end
    end
    vsync = 1'b1;
    cyc();
    m_div = 0;
    prev_fc = m_fc;
    checks++;
    if ({sync_reset, video_en, frame_start, anim_tick} !== 4'b1000) begin
      errors++;
      $display("FAIL lock_loss_outputs: got sr/ve/fs/at=%b, expected 1000",
               {sync_reset, video_en, frame_start, anim_tick});
    end
    checks++;
    if ({anim_frame, frame_count} !== {4'(m_anim), 16'(m_fc)}) begin
      errors++;
      $display("FAIL lock_loss_hold: got af=%0d fc=%0d, expected af=%0d fc=%0d",
               anim_frame, frame_count, m_anim, m_fc);
    end
    $display("lock lost at fc=%0d anim=%0d", frame_count, anim_frame);
    for (int i = 0; i < 6; i++) begin
      vsync = (i % 3 == 0) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if ({video_en, frame_start, sync_reset} !== 3'b001) begin
        errors++;
        $display("FAIL unlocked_quiet: got ve/fs/sr=%b, expected 001", {video_en, frame_start, sync_reset});
      end
    end
    vsync = 1'b1;
    bring_up(32'hFFFF_FFFF, 1'b0);
    do_frame(1'b0, 3);
    checks++;
    if (frame_count !== 16'(prev_fc + 1)) begin
      errors++;
      $display("FAIL relock_frame_count: got %0d, expected %0d", frame_count, prev_fc + 1);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) do_frame(1'($urandom_range(0, 1)), $urandom_range(2, 8));
  endtask

  task automatic test_async_reset();
    do_frame(1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sync_reset, video_en, frame_start, anim_tick, anim_frame, frame_count} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0}) begin
      errors++;
      $display("FAIL async_reset: got sr=%0b ve=%0b fs=%0b at=%0b af=%0d fc=%0d, expected 1 0 0 0 0 0",
               sync_reset, video_en, frame_start, anim_tick, anim_frame, frame_count);
    end
    $display("async reset applied mid-cycle");
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    test_startup();
    test_lock_glitch();
    test_animation();
    test_pause();
    test_lock_loss();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
